// File: rtl/axi_lite_master.sv
// Purpose: bridges a single-outstanding core load/store port onto an AXI4-Lite master.
// Latency: accept -> resp_valid in 3 cycles minimum; each slave stall cycle adds one.
// Backpressure: req_ready low while a transaction is in flight; core holds req_valid.
//
// Ports: clk/rst (async active-high); req_* core request in, req_ready out;
//        resp_valid/resp_rdata/resp_err completion out; m_axi_* AR/R/AW/W/B channels.
// Build option: define AXI_RESP_CHECK_EN to report non-OKAY rresp/bresp on resp_err;
//        when undefined, resp_err is always 0 and rresp/bresp are ignored.
module axi_lite_master (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    output logic [2:0]  m_axi_awprot,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        rd_err, wr_err;

`ifdef AXI_RESP_CHECK_EN
    assign rd_err = (m_axi_rresp != 2'b00);
    assign wr_err = (m_axi_bresp != 2'b00);
`else
    assign rd_err = 1'b0;
    assign wr_err = 1'b0;
    logic unused_resp;
    assign unused_resp = ^{m_axi_rresp, m_axi_bresp};
`endif

    // All AXI outputs decode from registered state so no input reaches an output
    // combinationally. aw/w valids fall the cycle after their own handshake.
    assign req_ready     = (state_q == IDLE) && !rst;
    assign m_axi_arvalid = (state_q == RD_ADDR);
    assign m_axi_rready  = (state_q == RD_DATA);
    assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WR_REQ) && !w_done_q;
    assign m_axi_bready  = (state_q == WR_RESP);
    assign m_axi_araddr  = addr_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awprot  = 3'b000;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = {req_addr[31:2], 2'b00};
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = req_we ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (m_axi_arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    resp_rdata_d = m_axi_rdata;
                    resp_err_d   = rd_err;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            WR_REQ: begin
                if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
                // Both channels may complete in either order or together.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    resp_err_d   = wr_err;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a transaction-level model tracks which AXI handshakes
// of the current request have completed and predicts every output each cycle; a
// behavioural slave with programmable stalls answers the bus.
`timescale 1ns/1ps
module tb_axi_lite_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_wdata;
    logic        m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready;
    logic [2:0]  m_axi_arprot, m_axi_awprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0, m_axi_awready = 1'b0;
    logic        m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0, m_axi_bresp = '0;

    axi_lite_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arprot(m_axi_arprot), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awprot(m_axi_awprot), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

`ifdef AXI_RESP_CHECK_EN
    localparam bit EXP_ERR_SLVERR = 1'b1;
`else
    localparam bit EXP_ERR_SLVERR = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    function automatic bit err_of(input logic [1:0] r);
`ifdef AXI_RESP_CHECK_EN
        return r != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- model state ----------------
    int          cyc = 0;
    bit          busy = 0, t_we = 0, ar_d = 0, aw_d = 0, w_d = 0, pulse = 0, exp_err = 0;
    logic [31:0] t_addr = '0, t_wdata = '0, exp_rdata = '0;
    logic [3:0]  t_wstrb = '0;
    bit          acc_ev = 0;
    int          acc_cyc = 0, ar_hs_cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0, dut_pulses = 0;
    logic [31:0] last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    // slave configuration and stall counters
    int          ar_stall = 0, r_stall = 0, aw_stall = 0, w_stall = 0, b_stall = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

    bit ea, er, eaw, ew, eb;
    wire e_arvalid = busy && !t_we && !ar_d;
    wire e_rready  = busy && !t_we && ar_d;
    wire e_awvalid = busy && t_we && !aw_d;
    wire e_wvalid  = busy && t_we && !w_d;
    wire e_bready  = busy && t_we && aw_d && w_d;

    always @(posedge clk) cyc <= cyc + 1;

    // Model update: acceptance and handshakes as seen at each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy = 0; ar_d = 0; aw_d = 0; w_d = 0; pulse = 0;
            exp_rdata = '0; exp_err = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            ea = e_arvalid; er = e_rready; eaw = e_awvalid; ew = e_wvalid; eb = e_bready;
            pulse = 0;
            ar_cnt = (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
            r_cnt  = (m_axi_rready  && !m_axi_rvalid)  ? r_cnt + 1  : 0;
            aw_cnt = (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
            w_cnt  = (m_axi_wvalid  && !m_axi_wready)  ? w_cnt + 1  : 0;
            b_cnt  = (m_axi_bready  && !m_axi_bvalid)  ? b_cnt + 1  : 0;
            if (req_valid && !busy) begin
                busy = 1; t_we = req_we; t_addr = {req_addr[31:2], 2'b00};
                t_wdata = req_wdata; t_wstrb = req_wstrb;
                ar_d = 0; aw_d = 0; w_d = 0; acc_cyc = cyc; acc_ev = 1;
            end
            if (ea && m_axi_arready) begin
                ar_d = 1; ar_hs_cyc = cyc; last_araddr = m_axi_araddr;
            end
            if (er && m_axi_rvalid) begin
                busy = 0; pulse = 1; exp_rdata = m_axi_rdata; exp_err = err_of(m_axi_rresp);
            end
            if (eaw && m_axi_awready) begin
                aw_d = 1; aw_hs_cyc = cyc; last_awaddr = m_axi_awaddr;
            end
            if (ew && m_axi_wready) begin
                w_d = 1; w_hs_cyc = cyc; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
            end
            if (eb && m_axi_bvalid) begin
                busy = 0; pulse = 1; exp_err = err_of(m_axi_bresp);
            end
        end
    end

    // Behavioural slave: answers after a programmable number of wait cycles.
    initial forever begin
        @(negedge clk);
        m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_stall);
        m_axi_rvalid  = m_axi_rready  && (r_cnt  >= r_stall);
        m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_stall);
        m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_stall);
        m_axi_bvalid  = m_axi_bready  && (b_cnt  >= b_stall);
        m_axi_rdata   = cfg_rdata;
        m_axi_rresp   = cfg_rresp;
        m_axi_bresp   = cfg_bresp;
    end

    // Per-cycle comparison of every DUT output against the model.
    initial forever begin
        @(negedge clk);
        chk("req_ready", req_ready, !rst && !busy);
        chk("arvalid", m_axi_arvalid, e_arvalid);
        chk("rready", m_axi_rready, e_rready);
        chk("awvalid", m_axi_awvalid, e_awvalid);
        chk("wvalid", m_axi_wvalid, e_wvalid);
        chk("bready", m_axi_bready, e_bready);
        chk("arprot", m_axi_arprot, 0);
        chk("awprot", m_axi_awprot, 0);
        chk("resp_valid", resp_valid, pulse);
        chk("resp_rdata", resp_rdata, exp_rdata);
        if (e_arvalid) chk("araddr_stable", m_axi_araddr, t_addr);
        if (e_awvalid) chk("awaddr_stable", m_axi_awaddr, t_addr);
        if (e_wvalid) begin
            chk("wdata_stable", m_axi_wdata, t_wdata);
            chk("wstrb_stable", m_axi_wstrb, t_wstrb);
        end
        if (pulse) chk("resp_err", resp_err, exp_err);
        if (resp_valid) dut_pulses++;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        bit got;
        got = 0;
        acc_ev = 0;
        req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (acc_ev) begin got = 1; break; end
        end
        req_valid = 0;
        if (!got) fail_now("accept_timeout");
    endtask

    task automatic wait_resp(output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (resp_valid) begin got = 1; lat = cyc - acc_cyc; break; end
            @(negedge clk);
        end
        if (!got) fail_now("resp_timeout");
    endtask

    int lat, snap, b2b_cyc;
    bit got_rr;

    initial begin
        // reset state
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_arvalid", m_axi_arvalid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        idle(3);
        rst = 0;
        idle(2);

        // aligned load, no stalls
        cfg_rdata = 32'hDEAD_BEEF;
        issue(0, 32'h0000_1004, 0, 0);
        wait_resp(lat);
        chk("load_latency", lat, 3);
        chk("load_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("load_araddr", last_araddr, 32'h0000_1004);
        chk("load_err", resp_err, 0);

        // store, wready 3 cycles ahead of awready
        idle(2);
        snap = dut_pulses;
        aw_stall = 3;
        issue(1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
        wait_resp(lat);
        chk("store_latency", lat, 6);
        chk("store_aw_after_w", aw_hs_cyc - w_hs_cyc, 3);
        chk("store_awaddr", last_awaddr, 32'h0000_0010);
        chk("store_wdata", last_wdata, 32'h1234_5678);
        chk("store_wstrb", last_wstrb, 4'b0011);
        chk("store_keeps_rdata", resp_rdata, 32'hDEAD_BEEF);
        aw_stall = 0;
        idle(3);
        chk("store_one_pulse", dut_pulses - snap, 1);

        // back-to-back: load offered in the store's completion cycle
        issue(1, 32'h0000_0020, 32'hA5A5_A5A5, 4'b1111);
        wait_resp(lat);
        chk("b2b_store_latency", lat, 3);
        b2b_cyc = cyc;
        cfg_rdata = 32'h0BAD_F00D;
        issue(0, 32'h0000_0024, 0, 0);
        chk("b2b_accept_cycle", acc_cyc, b2b_cyc);
        wait_resp(lat);
        chk("b2b_ar_next_cycle", ar_hs_cyc - acc_cyc, 1);
        chk("b2b_load_latency", lat, 3);
        chk("b2b_rdata", resp_rdata, 32'h0BAD_F00D);

        // stalled load: +5 on arready, +4 on rvalid
        idle(2);
        ar_stall = 5; r_stall = 4;
        cfg_rdata = 32'h55AA_33CC;
        issue(0, 32'h0000_1007, 0, 0);
        wait_resp(lat);
        chk("stall_latency", lat, 12);
        chk("stall_araddr", last_araddr, 32'h0000_1004);
        chk("stall_rdata", resp_rdata, 32'h55AA_33CC);
        ar_stall = 0; r_stall = 0;

        // SLVERR on store, aw ahead of w by 2 cycles
        idle(2);
        cfg_bresp = 2'b10; w_stall = 2;
        issue(1, 32'h0000_0040, 32'hFFFF_0000, 4'b1100);
        wait_resp(lat);
        chk("err_latency", lat, 5);
        chk("err_resp_err", resp_err, EXP_ERR_SLVERR);
        chk("err_keeps_rdata", resp_rdata, 32'h55AA_33CC);
        cfg_bresp = 2'b00; w_stall = 0;

        // zero-strobe store is still issued; address low bits dropped
        idle(2);
        issue(1, 32'h0000_0033, 32'h0000_00FF, 4'b0000);
        wait_resp(lat);
        chk("zstrb_latency", lat, 3);
        chk("zstrb_awaddr", last_awaddr, 32'h0000_0030);
        chk("zstrb_wstrb", last_wstrb, 4'b0000);
        chk("zstrb_err", resp_err, 0);

        // reset while waiting for read data
        idle(2);
        r_stall = 20;
        cfg_rdata = 32'h1111_2222;
        issue(0, 32'h0000_2000, 0, 0);
        got_rr = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_axi_rready) begin got_rr = 1; break; end
            @(negedge clk);
        end
        if (!got_rr) fail_now("rready_timeout");
        idle(1);
        snap = dut_pulses;
        #2 rst = 1;
        #1;
        chk("midrst_rready", m_axi_rready, 0);
        chk("midrst_arvalid", m_axi_arvalid, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_rdata", resp_rdata, 0);
        idle(2);
        rst = 0;
        r_stall = 0;
        idle(4);
        chk("midrst_no_pulse", dut_pulses - snap, 0);
        cfg_rdata = 32'hCAFE_F00D;
        issue(0, 32'h0000_2008, 0, 0);
        wait_resp(lat);
        chk("postrst_latency", lat, 3);
        chk("postrst_rdata", resp_rdata, 32'hCAFE_F00D);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
